// File: rtl/zero_test_arbiter.sv
// zero_test_arbiter
// Shares one WIDTH-bit subtract-and-zero-detect unit between two requesters
// (port 0: CPU branch compare, port 1: game-logic collision compare).
// A request is granted in IDLE, the difference is reduced to an
// "equal / is-zero" flag in COMPUTE, and the flag is returned to the
// granted port in RESPOND over a valid/ready handshake.
//
// Build option:
//   ZERO_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins contention and
//                                        no round-robin pointer is built.
//                           undefined -> round-robin between the ports
//                                        (default).

module zero_test_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   output logic             rsp0_valid,
   output logic             rsp0_zero,
   input  logic             rsp0_ready,

   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             rsp1_valid,
   output logic             rsp1_zero,
   input  logic             rsp1_ready,

   output logic             busy
);

   // State encoding kept as plain constants so the block drops into
   // older flows that do not accept enum-typed state registers.
   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_COMPUTE = 2'b01;
   localparam logic [1:0] S_RESPOND = 2'b10;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;

   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] w_diff;
   logic             r_gnt;
   logic             r_zero;
   logic             r_busy;

   logic             w_sel;
   logic             w_any_valid;
   logic             w_accept;
   logic             w_rsp_ready_gnt;
   logic             w_rsp_hs;

`ifndef ZERO_ARB_FIXED_PRIO_EN
   // Port granted most recently; the other port wins the next contention.
   logic             r_last;
`endif

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------

   // Pick the winner among the valid requesters (0 = port 0, 1 = port 1).
   // NOTE: every signal assigned in an always_comb gets a default on the
   // first line so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_sel = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef ZERO_ARB_FIXED_PRIO_EN
         w_sel = 1'b0;
`else
         w_sel = ~r_last;
`endif
      end else if (req1_valid) begin
         w_sel = 1'b1;
      end
   end

   assign w_any_valid = req0_valid | req1_valid;

   // A request can only be taken while the shared unit is idle; the
   // requester that loses simply keeps its valid high and waits.
   assign w_accept   = (r_state == S_IDLE) && w_any_valid;
   assign req0_ready = w_accept && !w_sel;
   assign req1_ready = w_accept &&  w_sel;

   // ------------------------------------------------------------------
   // Response handshake
   // ------------------------------------------------------------------

   // Only the granted port's ready matters; a ready from the other port
   // (whose valid is low) is ignored.
   assign w_rsp_ready_gnt = r_gnt ? rsp1_ready : rsp0_ready;
   assign w_rsp_hs        = (r_state == S_RESPOND) && w_rsp_ready_gnt;

   assign rsp0_valid = (r_state == S_RESPOND) && !r_gnt;
   assign rsp1_valid = (r_state == S_RESPOND) &&  r_gnt;

   // The flag is gated by the port's valid so the idle port always reads 0.
   assign rsp0_zero  = rsp0_valid && r_zero;
   assign rsp1_zero  = rsp1_valid && r_zero;

   assign busy = r_busy;

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------

   // Modulo-2^WIDTH difference: the borrow falls off the top, so
   // 0 - 'hFFFF_FFFF yields 1, not a negative value.
   assign w_diff = r_op_a - r_op_b;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------

   // Next-state decode: IDLE -> COMPUTE on accept, COMPUTE -> RESPOND
   // unconditionally, RESPOND -> IDLE on the response handshake.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any_valid) begin
               w_state_nxt = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            w_state_nxt = S_RESPOND;
         end
         S_RESPOND: begin
            if (w_rsp_ready_gnt) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register plus a registered busy flag that follows the state
   // one cycle behind the decode, i.e. high whenever the FSM is not IDLE.
   // NOTE: all clocked state is written with non-blocking assignments so
   // every flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   // Capture the winner's operands and identity on accept.
   // NOTE: these datapath registers are reset even though every use is
   // qualified by the FSM; the count is tiny and it keeps the block
   // X-free after reset in simulation and at power-up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_a <= '0;
         r_op_b <= '0;
         r_gnt  <= 1'b0;
      end else if (w_accept) begin
         r_gnt  <= w_sel;
         r_op_a <= w_sel ? req1_a : req0_a;
         r_op_b <= w_sel ? req1_b : req0_b;
      end
   end

   // Register the equal flag in COMPUTE; it is held through RESPOND so
   // the response stays stable under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zero <= 1'b0;
      end else if (r_state == S_COMPUTE) begin
         r_zero <= ~(|w_diff);
      end
   end

`ifndef ZERO_ARB_FIXED_PRIO_EN
   // Round-robin pointer: updated only when a response is actually
   // consumed, so an aborted operation never moves it. Reset to 1 so
   // port 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (w_rsp_hs) begin
         r_last <= r_gnt;
      end
   end
`endif

endmodule

// File: tb/tb_zero_test_arbiter.sv
// tb_zero_test_arbiter
// Scoreboard bench for zero_test_arbiter: expected flags are queued per
// port at accept time and popped by a monitor when each response is
// consumed. Scenario tasks check reset state, latency, wrap-around,
// contention order, back-pressure and reset during an operation.
// Define ZERO_ARB_FIXED_PRIO_EN for both DUT and bench to test that build.

module tb_zero_test_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_zero, rsp1_zero;
   logic        rsp0_ready, rsp1_ready;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   bit q0[$];
   bit q1[$];
   bit m_exp;

   zero_test_arbiter #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .rsp0_valid (rsp0_valid),
      .rsp0_zero  (rsp0_zero),
      .rsp0_ready (rsp0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_zero  (rsp1_zero),
      .rsp1_ready (rsp1_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Response monitor: pops the scoreboard on each consumed response and
   // checks that the idle port's response lines stay at 0.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp0_valid) begin
            n_total++;
            if ({rsp1_valid, rsp1_zero} !== 2'b00)
               $display("FAIL leak_to_port1: rsp1 valid/zero=%b required 00", {rsp1_valid, rsp1_zero});
            else n_pass++;
         end
         if (rsp1_valid) begin
            n_total++;
            if ({rsp0_valid, rsp0_zero} !== 2'b00)
               $display("FAIL leak_to_port0: rsp0 valid/zero=%b required 00", {rsp0_valid, rsp0_zero});
            else n_pass++;
         end
         if (rsp0_valid && rsp0_ready) begin
            n_total++;
            if (q0.size() == 0) begin
               $display("FAIL rsp0_unexpected: response zero=%b with no request outstanding", rsp0_zero);
            end else begin
               m_exp = q0.pop_front();
               if (rsp0_zero !== m_exp)
                  $display("FAIL rsp0_zero: got %b required %b", rsp0_zero, m_exp);
               else n_pass++;
            end
         end
         if (rsp1_valid && rsp1_ready) begin
            n_total++;
            if (q1.size() == 0) begin
               $display("FAIL rsp1_unexpected: response zero=%b with no request outstanding", rsp1_zero);
            end else begin
               m_exp = q1.pop_front();
               if (rsp1_zero !== m_exp)
                  $display("FAIL rsp1_zero: got %b required %b", rsp1_zero, m_exp);
               else n_pass++;
            end
         end
      end
   end

   task automatic apply_reset();
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q0.delete();
      q1.delete();
   endtask

   // Present one request, hold it until accepted (bounded), then drop it.
   // Returns in the cycle after acceptance (COMPUTE), 1 time unit after
   // the edge. acc is the cycle index of the accept, -1 on timeout.
   task automatic send_req(input int port, input logic [31:0] a, input logic [31:0] b,
                           input bit expect_rsp, output int acc);
      logic ready_seen;
      acc = -1;
      @(posedge clk); #1;
      if (port == 0) begin
         req0_a = a; req0_b = b; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_valid = 1'b1;
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         ready_seen = (port == 0) ? req0_ready : req1_ready;
         if (ready_seen) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) begin
         n_total++;
         $display("FAIL accept_timeout: port %0d never saw ready, required ready within 30 cycles", port);
      end else if (expect_rsp) begin
         if (port == 0) q0.push_back(a == b);
         else           q1.push_back(a == b);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_total++;
         $display("FAIL idle_timeout: busy=%b still high, required 0 within 30 cycles", busy);
      end
   endtask

   task automatic test_reset();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, busy} !== 7'b0)
         $display("FAIL reset_outputs: got %b required 0000000",
                  {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, busy});
      else n_pass++;
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_total++;
         if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, busy} !== 7'b0)
            $display("FAIL idle_outputs: cycle %0d got %b required 0000000", i,
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, busy});
         else n_pass++;
      end
   endtask

   task automatic test_single();
      int acc;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         send_req(0, 32'h0000_1234, (k == 0) ? 32'h0000_1234 : 32'h0000_1235, 1'b1, acc);
         @(negedge clk);  // COMPUTE
         n_total++;
         if ({rsp0_valid, busy, req0_ready, req1_ready} !== 4'b0100 || cyc != acc + 1)
            $display("FAIL compute_cycle: valid/busy/rdy0/rdy1=%b required 0100",
                     {rsp0_valid, busy, req0_ready, req1_ready});
         else n_pass++;
         @(negedge clk);  // RESPOND, consumed by monitor
         n_total++;
         if (rsp0_valid !== 1'b1 || cyc != acc + 2)
            $display("FAIL rsp_latency: rsp0_valid=%b at accept+%0d required 1 at accept+2",
                     rsp0_valid, cyc - acc);
         else n_pass++;
         @(negedge clk);
         n_total++;
         if ({rsp0_valid, busy} !== 2'b00)
            $display("FAIL rsp_drop: valid/busy=%b required 00", {rsp0_valid, busy});
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      int acc;
      send_req(1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, acc);
      wait_idle();
      send_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, acc);
      wait_idle();
      send_req(1, 32'h8000_0000, 32'h8000_0000, 1'b1, acc);
      wait_idle();
      n_total++;
      if (q0.size() + q1.size() != 0)
         $display("FAIL wrap_drain: %0d responses outstanding required 0", q0.size() + q1.size());
      else n_pass++;
   endtask

   task automatic test_contention();
      int exp_order[4];
      int n_acc = 0;
      int prev  = 0;
      int got;
      bit seen1 = 1'b0;
`ifdef ZERO_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0};
`else
      exp_order = '{0, 1, 0, 1};
`endif
      apply_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      @(posedge clk); #1;
      req0_a = 32'd5; req0_b = 32'd5; req1_a = 32'd7; req1_b = 32'd3;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 40 && n_acc < 4; i++) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            got = req1_ready ? 1 : 0;
            if (got == 0) q0.push_back(1'b1); else q1.push_back(1'b0);
            n_total++;
            if ((req0_ready && req1_ready) || got != exp_order[n_acc])
               $display("FAIL grant_order: op %0d granted port %0d required %0d", n_acc, got, exp_order[n_acc]);
            else n_pass++;
            if (n_acc > 0) begin
               n_total++;
               if (cyc - prev != 3)
                  $display("FAIL back_to_back: accept spacing %0d required 3", cyc - prev);
               else n_pass++;
            end
            prev = cyc;
            n_acc++;
         end
      end
      n_total++;
      if (n_acc != 4) $display("FAIL contention_count: %0d accepts required 4", n_acc);
      else n_pass++;
      // Port 0 drops out; port 1 must now be served.
      @(posedge clk); #1;
      req0_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (req1_ready) begin
            seen1 = 1'b1;
            q1.push_back(1'b0);
            break;
         end
      end
      n_total++;
      if (!seen1) $display("FAIL port1_after_drop: req1_ready=0 required 1 within 30 cycles");
      else n_pass++;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_idle();
      n_total++;
      if (q0.size() + q1.size() != 0)
         $display("FAIL contention_drain: %0d responses outstanding required 0", q0.size() + q1.size());
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int acc;
      rsp1_ready = 1'b0; rsp0_ready = 1'b1;
      send_req(1, 32'd42, 32'd42, 1'b1, acc);
      req0_a = 32'd9; req0_b = 32'd8; req0_valid = 1'b1;
      @(negedge clk);  // COMPUTE
      n_total++;
      if (req0_ready !== 1'b0) $display("FAIL bp_compute_ready: req0_ready=%b required 0", req0_ready);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_total++;
         if ({rsp1_valid, rsp1_zero, req0_ready, req1_ready} !== 4'b1100)
            $display("FAIL bp_hold: cycle %0d valid/zero/rdy0/rdy1=%b required 1100", i,
                     {rsp1_valid, rsp1_zero, req0_ready, req1_ready});
         else n_pass++;
      end
      @(posedge clk); #1;
      rsp1_ready = 1'b1;
      @(negedge clk);  // handshake cycle
      n_total++;
      if ({rsp1_valid, req0_ready} !== 2'b10 || cyc != acc + 7)
         $display("FAIL bp_handshake: valid/rdy0=%b at accept+%0d required 10 at accept+7",
                  {rsp1_valid, req0_ready}, cyc - acc);
      else n_pass++;
      @(negedge clk);  // cycle after handshake: port 0 accepted
      n_total++;
      if (req0_ready !== 1'b1) $display("FAIL bp_next_accept: req0_ready=%b required 1", req0_ready);
      else begin
         n_pass++;
         q0.push_back(1'b0);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_idle();
   endtask

   task automatic test_reset_midop();
      int acc;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      send_req(0, 32'd1, 32'd1, 1'b1, acc);  // leaves last grant = port 0
      wait_idle();
      send_req(1, 32'd3, 32'd3, 1'b0, acc);  // in COMPUTE on return
      rst_n = 1'b0;
      @(negedge clk);
      n_total++;
      if ({busy, rsp0_valid, rsp1_valid} !== 3'b000)
         $display("FAIL midop_async: busy/v0/v1=%b required 000", {busy, rsp0_valid, rsp1_valid});
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_total++;
         if ({busy, rsp0_valid, rsp1_valid} !== 3'b000)
            $display("FAIL midop_no_rsp: cycle %0d busy/v0/v1=%b required 000", i, {busy, rsp0_valid, rsp1_valid});
         else n_pass++;
      end
      @(posedge clk); #1;
      req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd6; req1_b = 32'd6;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      n_total++;
      if ({req0_ready, req1_ready} !== 2'b10)
         $display("FAIL midop_regrant: rdy0/rdy1=%b required 10", {req0_ready, req1_ready});
      else begin
         n_pass++;
         q0.push_back(1'b1);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle();
      n_total++;
      if (q0.size() + q1.size() != 0)
         $display("FAIL midop_drain: %0d responses outstanding required 0", q0.size() + q1.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_contention();
      test_backpressure();
      test_reset_midop();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/zero_test_arbiter.md
# zero_test_arbiter

Shares one 32-bit subtract-and-zero-detect unit between two requesters: port 0 (CPU branch-compare path) and port 1 (game logic, e.g. snake head/body collision compare). Each requester hands in an operand pair; the block arbitrates, computes `a - b`, reduces the difference to a single "equal / is-zero" flag, and returns it over a per-port response handshake. It sits between the CPU datapath and the game-logic FSM in the top level, replacing duplicated comparators.

## Interface
- `WIDTH`, 32: operand width in bits.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req0_valid`  in  1  port 0 request present.
- `req0_a`, `req0_b`  in  WIDTH  port 0 operands.
- `req0_ready`  out  1  port 0 request accepted this cycle.
- `rsp0_valid`  out  1  port 0 result available.
- `rsp0_zero`  out  1  port 0 result: 1 when `a - b == 0` (mod 2^WIDTH).
- `rsp0_ready`  in  1  port 0 consumes result.
- `req1_*` / `rsp1_*`: identical set for port 1.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM with states IDLE, COMPUTE and RESPOND; reset state is IDLE.
- **IDLE**
  - With no `reqN_valid` high, stay in IDLE.
  - Otherwise pick the winner:
    - If only one port is valid, that port wins.
    - If both are valid, the port not granted last wins (round-robin).
  - Assert the winner's `reqN_ready` in that same cycle. It is a combinational output, a function of state, the valids and the pointer.
  - Capture the operands into `op_a` and `op_b` and the winner into `gnt`.
  - Go to COMPUTE.
- **COMPUTE**
  - Register `diff = op_a - op_b`, computed modulo 2^WIDTH with the borrow discarded.
  - Register `zero = (diff == 0)`, i.e. the OR-reduce of `diff` inverted.
  - Go to RESPOND.
- **RESPOND**
  - Drive `rsp[gnt]_valid` high and `rsp[gnt]_zero` from the registered flag.
  - Both stay stable until `rsp[gnt]_ready` is high in the same cycle.
  - On that handshake:
    - Update the round-robin pointer `last = gnt`.
    - Go to IDLE.
    - `rsp_valid` drops the next cycle.
- A request that is not granted must be held by the requester; `reqN_ready` is never asserted outside IDLE.
- The response of the non-granted port is always 0.
- Pointer reset value: `last = 1`, so port 0 wins the first contention.
- Asserting `rspN_ready` while `rspN_valid` is low is ignored.
- Reset mid-operation (any state):
  - FSM returns to IDLE immediately and the pointer goes back to 1.
  - The in-flight result is discarded, and no response is issued for it.

## Timing
- Reset values: `req0_ready`, `req1_ready`, `rsp0_valid`, `rsp1_valid`, `rsp0_zero`, `rsp1_zero` and `busy` are all 0.
- Request accepted in cycle N, i.e. `valid && ready` at edge N.
  - COMPUTE in N+1.
  - `rspN_valid` high from N+2.
- With `rsp_ready` held high, the next accept is in N+3. Peak throughput is one operation per 3 cycles.
- Back-pressure: each extra cycle of low `rsp_ready` extends RESPOND by one cycle.
- Both ports valid continuously: grants alternate 0, 1, 0, 1, …
- `busy` is registered from state: it is high in N+1 through the handshake cycle.

## Configuration
- `ZERO_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. Port 0 always wins contention and the round-robin pointer is not built.
  - Undefined (default): round-robin as described above.
  - All other behaviour and timing are identical in both builds.

## Test plan
- Reset then idle: all outputs 0 and `busy` = 0 for 10 cycles with no valids.
- Single compare:
  - Port 0 requests `a=32'h0000_1234`, `b=32'h0000_1234`: `req0_ready` in the accept cycle, `rsp0_valid` 2 cycles later with `rsp0_zero` = 1.
  - Repeat with `b=32'h0000_1235`: `rsp0_zero` = 0.
- Wrap-around:
  - `a=0`, `b=32'hFFFF_FFFF`: `diff` = 1, so `rsp_zero` = 0.
  - `a=b=32'hFFFF_FFFF`: `rsp_zero` = 1.
- Contention:
  - Both ports valid for 4 operations: grant order is 0, 1, 0, 1, and each result is routed only to its own port.
  - With `ZERO_ARB_FIXED_PRIO_EN` defined, port 0 wins every contention until it drops `req0_valid`.
- Back-pressure: hold `rsp1_ready` low for 5 cycles. `rsp1_valid` and `rsp1_zero` stay stable, neither `req_ready` asserts, and the next accept happens the cycle after the handshake plus one.
- Reset mid-op: assert `rst_n` = 0 during COMPUTE, release it, then check that no `rsp_valid` appears and that the next contention grants port 0.
